// File: rtl/led_afterglow_driver_if.sv
// led_afterglow_driver_if: bundles the counter word feeding the afterglow
// driver with the LED drive and glow-status signals it returns.
// master = counter side (drives count_in), slave = afterglow driver.
`timescale 1ns/1ps
interface led_afterglow_driver_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] count_in;
  logic [WIDTH-1:0] led;
  logic             any_glow;

  modport master (
    output count_in,
    input  led,
    input  any_glow
  );

  modport slave (
    input  count_in,
    output led,
    output any_glow
  );
endinterface

// File: rtl/led_afterglow_driver.sv
// led_afterglow_driver: drives one LED per counter bit. A lit bit shows full
// brightness; a cleared bit fades out linearly, one brightness step per
// DECAY_DIV cycles, rendered by a shared PWM counter.
// Optional build macro LED_AFTERGLOW_GAMMA_EN applies a squared perceptual
// curve to the brightness before the PWM compare.
`timescale 1ns/1ps
module led_afterglow_driver #(
  parameter int WIDTH     = 8,
  parameter int PWM_BITS  = 4,
  parameter int DECAY_DIV = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  led_afterglow_driver_if.slave bus
);

  localparam int                 MAX_I    = (1 << PWM_BITS) - 1;
  localparam logic [PWM_BITS-1:0] MAX      = PWM_BITS'(MAX_I);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(MAX_I - 1);
  // A one-cycle divider still needs a 1-bit prescaler register.
  localparam int                 PRE_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(DECAY_DIV - 1);

  // Brightness floor at zero; a faded LED never wraps back to full.
  function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] v);
    return (v == '0) ? '0 : v - PWM_BITS'(1);
  endfunction

`ifdef LED_AFTERGLOW_GAMMA_EN
  // Squared curve scaled back to PWM_BITS; full brightness kept exact so a
  // lit LED remains solidly on.
  function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] v);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, v} * {{PWM_BITS{1'b0}}, v};
    return (v == MAX) ? MAX : sq[2*PWM_BITS-1:PWM_BITS];
  endfunction
`endif

  logic [WIDTH-1:0]    cnt_p0;
  logic [PWM_BITS-1:0] bright_p1 [WIDTH];
  logic [WIDTH-1:0]    led_p2;
  logic                glow_p2;

  logic [PRE_W-1:0]    pre_cnt;
  logic                decay_tick;
  logic [PWM_BITS-1:0] pwm_cnt;

  logic [PWM_BITS-1:0] eff [WIDTH];
  logic [WIDTH-1:0]    led_nxt;
  logic                glow_nxt;

  // ---- stage p0: capture the counter word every cycle ----
  // Register the incoming counter value; no handshake, every word is used.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_p0 <= '0;
    else       cnt_p0 <= bus.count_in;
  end

  // Fade-step prescaler: counts 0..DECAY_DIV-1 and wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 pre_cnt <= '0;
    else if (pre_cnt == PRE_LAST) pre_cnt <= '0;
    else                       pre_cnt <= pre_cnt + PRE_W'(1);
  end

  assign decay_tick = (pre_cnt == PRE_LAST);

  // Shared PWM phase: free-running over 0..MAX-1 so MAX means solid on.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  pwm_cnt <= '0;
    else if (pwm_cnt == PWM_LAST) pwm_cnt <= '0;
    else                        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  // ---- stage p1: per-channel brightness ----
  // A lit bit snaps to full brightness and wins over a coincident fade step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) bright_p1[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cnt_p0[i])       bright_p1[i] <= MAX;
        else if (decay_tick) bright_p1[i] <= sat_dec(bright_p1[i]);
      end
    end
  end

  // Effective duty per channel and the glow summary, ahead of the output flops.
  always_comb begin
    led_nxt  = '0;
    glow_nxt = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
`ifdef LED_AFTERGLOW_GAMMA_EN
      eff[i] = gamma(bright_p1[i]);
`else
      eff[i] = bright_p1[i];
`endif
      led_nxt[i] = (eff[i] > pwm_cnt);
      if (bright_p1[i] != '0) glow_nxt = 1'b1;
    end
  end

  // ---- stage p2: registered LED drive and glow flag ----
  // Outputs are registered so the pins never see compare glitches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_p2  <= '0;
      glow_p2 <= 1'b0;
    end else begin
      led_p2  <= led_nxt;
      glow_p2 <= glow_nxt;
    end
  end

  assign bus.led      = led_p2;
  assign bus.any_glow = glow_p2;

endmodule
